// File: rtl/mux_sel_pipe.sv
// Registered N:1 operand selector with valid/ready handshaking on every input
// and on the output. Supports direct select or round-robin among valid channels.
module mux_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

    // Returns {found, index}: first valid channel after 'last', wrapping, with
    // 'last' itself considered only after every other channel.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_IN-1:0] vld,
                                               input logic [SEL_W-1:0]  last);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        int               c;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            c = int'(last) + k;
            if (c >= NUM_IN) begin
                c = c - NUM_IN;
            end
            cand = SEL_W'(c);
            if (vld[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             sel_in_range;
    logic             chosen_vld;
    logic [SEL_W-1:0] chosen;
    logic [WIDTH-1:0] chosen_data;
    logic             space;
    logic             accept;

    generate
        if ((1 << SEL_W) == NUM_IN) begin : g_sel_full
            assign sel_in_range = 1'b1;
        end else begin : g_sel_part
            assign sel_in_range = (sel <= LAST_CH);
        end
    endgenerate

    always_comb begin
        chosen_vld = 1'b0;
        chosen     = '0;
        if (mode) begin
            {chosen_vld, chosen} = rr_pick(in_valid, last_grant_q);
        end else begin
            chosen_vld = sel_in_range;
            chosen     = sel;
        end
    end

    always_comb begin
        chosen_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (chosen == SEL_W'(i)) begin
                chosen_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign space = !out_valid_q || out_ready;

    // Reset blocks every grant so nothing is consumed from upstream while the
    // held word is being discarded.
    always_comb begin
        in_ready = '0;
        if (space && chosen_vld && !rst) begin
            in_ready[chosen] = 1'b1;
        end
    end

    assign accept = |(in_ready & in_valid);

    always_comb begin
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_data_d   = chosen_data;
            out_sel_d    = chosen;
            out_valid_d  = 1'b1;
            last_grant_d = chosen;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= LAST_CH;
        end else begin
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: directed scenarios plus random traffic, with a
// queue-based scoreboard fed by a spec-level model and drained by a monitor.
module tb_mux_sel_pipe;

    localparam int W = 32;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [2:0]     sel;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_valid;
    logic           out_ready;

    logic [39:0]    in_data5;
    logic [4:0]     in_valid5;
    logic [4:0]     in_ready5;
    logic           mode5;
    logic [2:0]     sel5;
    logic [7:0]     out_data5;
    logic [2:0]     out_sel5;
    logic           out_valid5;
    logic           out_ready5;

    mux_sel_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_sel_pipe #(.WIDTH(8), .NUM_IN(5)) dut5 (
        .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
        .out_sel(out_sel5), .out_valid(out_valid5), .out_ready(out_ready5)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           ch;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] dat[N];
    logic         mv  = 1'b0;
    int           ptr = N - 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.d));
                chk("out_sel", 64'(out_sel), 64'(e.ch));
            end
        end
    end

    // One clock of stimulus; the model decides grant/transfer from the rules.
    task automatic step(input bit r, input bit m, input int s, input logic [N-1:0] v, input bit ordy);
        bit         space;
        bit         have;
        int         ch;
        logic [N-1:0] exp_rdy;
        rst       = r;
        mode      = m;
        sel       = 3'(s);
        in_valid  = v;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(mv));
        space = !mv || ordy;
        have  = 0;
        ch    = 0;
        if (!m) begin
            if (s < N) begin
                have = 1;
                ch   = s;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (ptr + k) % N;
                if (!have && v[c]) begin
                    have = 1;
                    ch   = c;
                end
            end
        end
        exp_rdy = (!r && space && have) ? (N'(1) << ch) : '0;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (r) begin
            mv  = 0;
            ptr = N - 1;
            q.delete();
        end else if (have && space && v[ch]) begin
            q.push_back('{dat[ch], ch});
            mv  = 1;
            ptr = ch;
        end else if (mv && ordy) begin
            mv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq3[6] = '{0, 2, 5, 7, 0, 2};
        logic [W-1:0] word_a;
        logic [W-1:0] word_c;

        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1; in_data = '0;
        mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F; out_ready5 = 1'b1;
        in_data5 = {$urandom, $urandom_range(0, 255)};
        for (int i = 0; i < N; i++) dat[i] = $urandom;

        step(1, 0, 0, '0, 1);
        step(1, 0, 0, '0, 1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sel", 64'(out_sel), 64'd0);

        // Direct select of channel 3
        dat[3] = 32'hDEAD_BEEF;
        step(0, 0, 3, 8'h08, 1);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("t1_sel", 64'(out_sel), 64'd3);
        step(0, 0, 3, 8'h08, 1);
        step(0, 0, 0, 8'h00, 1);

        // Stall holds the word; sel/data changes during the stall are ignored
        word_a = $urandom;
        dat[5] = word_a;
        step(0, 0, 5, 8'h20, 1);
        dat[5] = ~word_a;
        word_c = $urandom;
        dat[2] = word_c;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2, 8'h24, 0);
            chk("t2_hold_data", 64'(out_data), 64'(word_a));
            chk("t2_hold_sel", 64'(out_sel), 64'd5);
        end
        step(0, 0, 2, 8'h24, 1);
        chk("t2_next_sel", 64'(out_sel), 64'd2);
        chk("t2_next_data", 64'(out_data), 64'(word_c));
        step(0, 0, 0, 8'h00, 1);

        // Round-robin over a fixed valid pattern
        step(1, 0, 0, '0, 1);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) dat[i] = $urandom;
            step(0, 1, 0, 8'hA5, 1);
            chk("t3_rr_sel", 64'(out_sel), 64'(seq3[k]));
            chk("t3_rr_valid", 64'(out_valid), 64'd1);
        end

        // Wrap-around from channel 7
        step(0, 1, 0, 8'h80, 1);
        chk("t4_sel7", 64'(out_sel), 64'd7);
        step(0, 1, 0, 8'h81, 1);
        chk("t4_wrap0", 64'(out_sel), 64'd0);
        step(0, 1, 0, 8'h81, 1);
        chk("t4_back7", 64'(out_sel), 64'd7);
        step(0, 1, 0, 8'h00, 1);

        // Out-of-range select on the 5-channel instance never grants
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 8'h00, 1);
            chk("t5_in_ready", 64'(in_ready5), 64'd0);
            chk("t5_out_valid", 64'(out_valid5), 64'd0);
        end

        // Reset discards a held word and restarts round-robin at channel 0
        step(0, 0, 4, 8'h10, 1);
        step(0, 0, 4, 8'h10, 0);
        step(1, 0, 4, 8'hFF, 1);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_data", 64'(out_data), 64'd0);
        chk("t6_sel", 64'(out_sel), 64'd0);
        step(0, 1, 0, 8'h64, 1);
        chk("t6_first_rr", 64'(out_sel), 64'd2);

        for (int n = 0; n < 3000; n++) begin
            bit r;
            bit m;
            bit rd;
            for (int i = 0; i < N; i++) dat[i] = $urandom;
            r  = ($urandom_range(0, 99) == 0);
            m  = $urandom_range(0, 1) == 1;
            rd = ($urandom_range(0, 3) != 0);
            step(r, m, $urandom_range(0, 7), N'($urandom), rd);
        end

        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
